// File: rtl/ccm_pkg.sv
// Shared types and sizing helpers for the closely-coupled memory responder.
package ccm_pkg;
  localparam int ICCM_DEPTH_DEF = 1024;
  localparam int DCCM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} ccm_state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ccm_sram.sv
// 1W1R synchronous word RAM; a read that collides with a write returns the new data.
module ccm_sram
  import ccm_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ccm_responder.sv
// ICCM/DCCM responder: boot-loads the ICCM from a word stream, then releases core reset
// and serves instruction and data accesses with range checking.
module ccm_responder
  import ccm_pkg::*;
#(
  parameter int ICCM_DEPTH = ICCM_DEPTH_DEF,
  parameter int DCCM_DEPTH = DCCM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iccm_rd_en,
  input  logic [31:0] iccm_rd_addr,
  output logic [31:0] iccm_rd_data,
  input  logic        dccm_wr_en,
  input  logic [31:0] dccm_wr_addr,
  input  logic [31:0] dccm_wr_data,
  input  logic        dccm_rd_en,
  input  logic [31:0] dccm_rd_addr,
  output logic [31:0] dccm_rd_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_rst_n,
  output logic        iccm_err,
  output logic        dccm_err
);
  localparam int IW = idx_w(ICCM_DEPTH);
  localparam int DW = idx_w(DCCM_DEPTH);

  ccm_state_e  state_q, state_d;
  logic [IW-1:0] load_ptr_q, load_ptr_d;
  logic core_rst_n_q, core_rst_n_d;
  logic iccm_err_q, iccm_err_d, dccm_err_q, dccm_err_d;
  logic iccm_zero_q, iccm_zero_d, dccm_zero_q, dccm_zero_d;
  logic [31:0] iccm_raw, dccm_raw;

  logic run, ld_accept, iccm_rd_ok, dccm_rd_ok, dccm_wr_ok;
  logic iccm_rd_oor, dccm_rd_oor, dccm_wr_oor;

  assign run         = (state_q == ST_RUN);
  assign ld_ready    = (state_q == ST_LOAD);
  assign ld_accept   = ld_ready && ld_valid;
  assign iccm_rd_oor = !(iccm_rd_addr < 32'(ICCM_DEPTH));
  assign dccm_rd_oor = !(dccm_rd_addr < 32'(DCCM_DEPTH));
  assign dccm_wr_oor = !(dccm_wr_addr < 32'(DCCM_DEPTH));
  assign iccm_rd_ok  = iccm_rd_en && run && !iccm_rd_oor;
  assign dccm_rd_ok  = dccm_rd_en && !dccm_rd_oor;
  assign dccm_wr_ok  = dccm_wr_en && !dccm_wr_oor;

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    core_rst_n_d = run;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: if (ld_accept) begin
        // The final slot ends the load instead of wrapping onto word 0.
        if (ld_last || (load_ptr_q == IW'(ICCM_DEPTH - 1))) state_d = ST_RUN;
        else load_ptr_d = load_ptr_q + IW'(1);
      end
      default: state_d = ST_RUN;
    endcase

    // Zero flags mask the RAM output and hold alongside it when no read is issued.
    iccm_zero_d = iccm_zero_q;
    if (iccm_rd_en) iccm_zero_d = !iccm_rd_ok;
    dccm_zero_d = dccm_zero_q;
    if (dccm_rd_en) dccm_zero_d = !dccm_rd_ok;

    iccm_err_d = iccm_rd_en && run && iccm_rd_oor;
    dccm_err_d = (dccm_rd_en && dccm_rd_oor) || (dccm_wr_en && dccm_wr_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      load_ptr_q   <= '0;
      core_rst_n_q <= 1'b0;
      iccm_err_q   <= 1'b0;
      dccm_err_q   <= 1'b0;
      iccm_zero_q  <= 1'b1;
      dccm_zero_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      core_rst_n_q <= core_rst_n_d;
      iccm_err_q   <= iccm_err_d;
      dccm_err_q   <= dccm_err_d;
      iccm_zero_q  <= iccm_zero_d;
      dccm_zero_q  <= dccm_zero_d;
    end
  end

  ccm_sram #(.DEPTH(ICCM_DEPTH)) u_iccm (
    .clk(clk), .rst_n(rst_n),
    .we(ld_accept), .waddr(load_ptr_q), .wdata(ld_data),
    .re(iccm_rd_ok), .raddr(iccm_rd_addr[IW-1:0]), .rdata(iccm_raw)
  );

  ccm_sram #(.DEPTH(DCCM_DEPTH)) u_dccm (
    .clk(clk), .rst_n(rst_n),
    .we(dccm_wr_ok), .waddr(dccm_wr_addr[DW-1:0]), .wdata(dccm_wr_data),
    .re(dccm_rd_ok), .raddr(dccm_rd_addr[DW-1:0]), .rdata(dccm_raw)
  );

  assign iccm_rd_data = iccm_zero_q ? 32'h0 : iccm_raw;
  assign dccm_rd_data = dccm_zero_q ? 32'h0 : dccm_raw;
  assign core_rst_n   = core_rst_n_q;
  assign iccm_err     = iccm_err_q;
  assign dccm_err     = dccm_err_q;
endmodule

// File: tb/tb_ccm_responder.sv
// Directed bench for ccm_responder with small memories (16 words each).
module tb_ccm_responder;
  localparam int ID = 16;
  localparam int DD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iccm_rd_en;
  logic [31:0] iccm_rd_addr;
  logic [31:0] iccm_rd_data;
  logic        dccm_wr_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_wr_data;
  logic        dccm_rd_en;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_rd_data;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        core_rst_n;
  logic        iccm_err;
  logic        dccm_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ccm_responder #(.ICCM_DEPTH(ID), .DCCM_DEPTH(DD)) dut (
    .clk(clk), .rst_n(rst_n),
    .iccm_rd_en(iccm_rd_en), .iccm_rd_addr(iccm_rd_addr), .iccm_rd_data(iccm_rd_data),
    .dccm_wr_en(dccm_wr_en), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .dccm_rd_en(dccm_rd_en), .dccm_rd_addr(dccm_rd_addr), .dccm_rd_data(dccm_rd_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .core_rst_n(core_rst_n), .iccm_err(iccm_err), .dccm_err(dccm_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ld_ready"},   32'(ld_ready),   32'h0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'h0);
    chk({tag, "_iccm_data"},  iccm_rd_data,    32'h0);
    chk({tag, "_dccm_data"},  dccm_rd_data,    32'h0);
    chk({tag, "_iccm_err"},   32'(iccm_err),   32'h0);
    chk({tag, "_dccm_err"},   32'(dccm_err),   32'h0);
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hBAD0_BAD0;
  endtask

  task automatic iccm_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input logic exp_err);
    iccm_rd_en = 1'b1; iccm_rd_addr = a;
    step();
    iccm_rd_en = 1'b0;
    chk({tag, "_data"}, iccm_rd_data, exp);
    chk({tag, "_err"},  32'(iccm_err), 32'(exp_err));
  endtask

  task automatic dccm_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    dccm_rd_en = 1'b1; dccm_rd_addr = a;
    step();
    dccm_rd_en = 1'b0;
    chk(tag, dccm_rd_data, exp);
  endtask

  task automatic dccm_write(input logic [31:0] a, input logic [31:0] d);
    dccm_wr_en = 1'b1; dccm_wr_addr = a; dccm_wr_data = d;
    step();
    dccm_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iccm_rd_en = 1'b0; iccm_rd_addr = '0;
    dccm_wr_en = 1'b0; dccm_wr_addr = '0; dccm_wr_data = '0;
    dccm_rd_en = 1'b0; dccm_rd_addr = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #2;
    chk_reset_outs("reset");
    step(); step();
    rst_n = 1'b1;
    chk("idle_ld_ready", 32'(ld_ready), 32'h0);
    step();
    chk("load_ld_ready", 32'(ld_ready), 32'h1);

    // ICCM read during LOAD returns 0 without error.
    iccm_read("rd_in_load", 32'd0, 32'h0, 1'b0);

    // Four-word load with a 3-cycle stall after word 2.
    load_word(32'h11, 1'b0);
    load_word(32'h22, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("stall_ld_ready", 32'(ld_ready), 32'h1);
    load_word(32'h33, 1'b0);
    chk("pre_last_ld_ready", 32'(ld_ready), 32'h1);
    load_word(32'h44, 1'b1);
    chk("after_last_ld_ready", 32'(ld_ready), 32'h0);
    chk("after_last_core_rst", 32'(core_rst_n), 32'h0);
    step();
    chk("run_core_rst", 32'(core_rst_n), 32'h1);

    // Words offered in RUN must be ignored.
    load_word(32'h99, 1'b0);
    iccm_read("iccm0", 32'd0, 32'h11, 1'b0);
    iccm_read("iccm1", 32'd1, 32'h22, 1'b0);
    iccm_read("iccm2", 32'd2, 32'h33, 1'b0);
    iccm_read("iccm3", 32'd3, 32'h44, 1'b0);
    step();
    chk("iccm_hold", iccm_rd_data, 32'h44);
    iccm_read("iccm_oor", 32'(ID), 32'h0, 1'b1);
    step();
    chk("iccm_err_pulse_end", 32'(iccm_err), 32'h0);
    chk("iccm_oor_hold", iccm_rd_data, 32'h0);

    // DCCM: plain write/read, write-first collision, independent ports.
    dccm_write(32'd0, 32'hA5A5_A5A5);
    dccm_write(32'd5, 32'hDEAD_BEEF);
    dccm_read("dccm5", 32'd5, 32'hDEAD_BEEF);
    dccm_wr_en = 1'b1; dccm_wr_addr = 32'd5; dccm_wr_data = 32'hCAFE_F00D;
    dccm_read("dccm5_wf", 32'd5, 32'hCAFE_F00D);
    dccm_wr_en = 1'b0;
    dccm_wr_en = 1'b1; dccm_wr_addr = 32'd6; dccm_wr_data = 32'h0000_1234;
    dccm_read("dccm_dual_rd", 32'd5, 32'hCAFE_F00D);
    dccm_wr_en = 1'b0;
    dccm_read("dccm_dual_wr", 32'd6, 32'h0000_1234);

    // Out-of-range read and write in one cycle: single error pulse, nothing modified.
    dccm_wr_en = 1'b1; dccm_wr_addr = 32'h8000_0000; dccm_wr_data = 32'hFFFF_FFFF;
    dccm_read("dccm_oor_data", 32'(DD), 32'h0);
    dccm_wr_en = 1'b0;
    chk("dccm_err_pulse", 32'(dccm_err), 32'h1);
    step();
    chk("dccm_err_end", 32'(dccm_err), 32'h0);
    dccm_read("dccm0_intact", 32'd0, 32'hA5A5_A5A5);
    dccm_read("dccm5_intact", 32'd5, 32'hCAFE_F00D);
    dccm_wr_en = 1'b1; dccm_wr_addr = 32'd16; dccm_wr_data = 32'h7777_7777;
    step();
    dccm_wr_en = 1'b0;
    chk("dccm_wr_oor_err", 32'(dccm_err), 32'h1);

    // Reset in the middle of a load, then reload from address 0.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    load_word(32'h55, 1'b0);
    load_word(32'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midload_rst");
    step();
    rst_n = 1'b1;
    step();

    // Full-depth load without ld_last; excess words must not be accepted.
    for (int i = 0; i < ID; i++) begin
      if (i == 4) begin iccm_rd_en = 1'b1; iccm_rd_addr = 32'd0; end
      load_word(32'h100 + 32'(i), 1'b0);
      if (i == 4) begin
        iccm_rd_en = 1'b0;
        chk("rd_in_reload", iccm_rd_data, 32'h0);
      end
      if (i == ID - 2) chk("full_pen_ld_ready", 32'(ld_ready), 32'h1);
    end
    chk("full_ld_ready", 32'(ld_ready), 32'h0);
    load_word(32'hEEEE_EEEE, 1'b0);
    chk("full_core_rst", 32'(core_rst_n), 32'h1);
    iccm_read("reload0",  32'd0,        32'h100, 1'b0);
    iccm_read("reload1",  32'd1,        32'h101, 1'b0);
    iccm_read("reload15", 32'(ID - 1),  32'h10F, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ccm_responder.md
CCM_RESPONDER -- requirements
Module: ccm_responder

Interface
REQ-001 Parameter ICCM_DEPTH, default 1024, ICCM size in 32-bit words (power of two).
REQ-002 Parameter DCCM_DEPTH, default 1024, DCCM size in 32-bit words (power of two).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 iccm_rd_en  in  1  core instruction read request.
REQ-006 iccm_rd_addr  in  32  word address of instruction read.
REQ-007 iccm_rd_data  out  32  instruction read data.
REQ-008 dccm_wr_en  in  1  core data write request.
REQ-009 dccm_wr_addr  in  32  word address of data write.
REQ-010 dccm_wr_data  in  32  data write value.
REQ-011 dccm_rd_en  in  1  core data read request.
REQ-012 dccm_rd_addr  in  32  word address of data read.
REQ-013 dccm_rd_data  out  32  data read value.
REQ-014 ld_valid  in  1  boot loader word valid.
REQ-015 ld_data  in  32  boot loader instruction word.
REQ-016 ld_last  in  1  marks final loader word.
REQ-017 ld_ready  out  1  responder accepts loader word.
REQ-018 core_rst_n  out  1  active-low reset to core, released after load.
REQ-019 iccm_err  out  1  one-cycle pulse: out-of-range ICCM access.
REQ-020 dccm_err  out  1  one-cycle pulse: out-of-range DCCM access.

Function
REQ-021 FSM states IDLE, LOAD, RUN; reset state IDLE; IDLE->LOAD unconditionally next cycle.
REQ-022 ld_ready SHALL be 1 exactly while state is LOAD, else 0.
REQ-023 In LOAD, each cycle with ld_valid&ld_ready writes ld_data to ICCM[load_ptr], load_ptr increments by 1 (load_ptr reset 0).
REQ-024 LOAD->RUN on an accepted word with ld_last=1, or on accepted word at load_ptr=ICCM_DEPTH-1 (no wrap; excess words never accepted).
REQ-025 core_rst_n SHALL be a register, 0 in IDLE/LOAD, set to 1 the cycle after RUN is entered; RUN is terminal until rst_n.
REQ-026 In RUN, ld_valid ignored, ICCM not writable.
REQ-027 Read latency: rd_data registered, valid the cycle after rd_en=1; with rd_en=0 rd_data holds last value.
REQ-028 ICCM reads while state is not RUN return 0, no error.
REQ-029 Address in range iff addr < DEPTH (full 32-bit compare); index = addr[log2(DEPTH)-1:0].
REQ-030 Out-of-range read: data 0 the next cycle, *_err pulse aligned with that data cycle.
REQ-031 Out-of-range DCCM write: dropped, dccm_err pulse next cycle; read and write errors in the same cycle give one pulse.
REQ-032 DCCM read and write to same in-range address in same cycle: read returns new wr_data (write-first).
REQ-033 DCCM read and write to different addresses in the same cycle both complete.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, load_ptr 0, iccm_rd_data 0, dccm_rd_data 0, iccm_err 0, dccm_err 0, core_rst_n 0.
REQ-035 Memory arrays SHALL NOT be reset; reset mid-load restarts load at address 0.

Structure
REQ-036 Package ccm_pkg SHALL hold default depths, index-width functions and the state enum.
REQ-037 Sub-module ccm_sram (1W1R synchronous, write-first, parameterised depth) SHALL be instantiated twice (ICCM, DCCM).

Verification
REQ-038 Load 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> ld_ready drops after 4th, core_rst_n=1 one cycle later; ICCM reads 0..3 return them one cycle after request.
REQ-039 ld_valid stalls 3 cycles mid-load -> load_ptr holds, no spurious writes, sequence intact.
REQ-040 DCCM write 0xDEADBEEF @5, then read @5 -> 0xDEADBEEF; same-cycle write 0xCAFEF00D/read @5 -> 0xCAFEF00D.
REQ-041 DCCM read @DCCM_DEPTH and write @0x8000_0000 -> data 0, dccm_err pulses, no in-range word modified.
REQ-042 Load ICCM_DEPTH words without ld_last -> RUN after last, ld_ready 0; ICCM read during LOAD -> 0.
REQ-043 Assert rst_n low mid-load after 2 words -> outputs at reset values immediately; reload starts at address 0.
